mac_stream_source: RTL and testbench

MAC_STREAM_SOURCE -- requirements
Module: mac_stream_source

---
 rtl/mac_package.sv | 19 +
 rtl/mac_stream_fifo.sv | 60 ++++++
 rtl/mac_stream_source.sv | 156 +++++++++++++++
 tb/tb_mac_stream_source.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_package.sv
// Shared types for the mac_stream_source slice: FSM state encoding and the decoded start request.
package mac_package;

   localparam int MAC_ADDR_W = 32;
   localparam int MAC_LEN_W  = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2
   } mac_src_state_t;

   typedef struct packed {
      logic [MAC_ADDR_W-1:0] base_addr;
      logic [MAC_LEN_W-1:0]  trans_size;
      logic                  req_start;
   } mac_src_ctrl_t;

endpackage

// File: rtl/mac_stream_fifo.sv
// Response buffer: power-of-two circular FIFO with a registered head word (reads 0 while empty).
module mac_stream_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       i_clear,
   input  logic                       i_push,
   input  logic [DATA_WIDTH-1:0]      i_data,
   input  logic                       i_pop,
   output logic [DATA_WIDTH-1:0]      o_data,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH):0]     o_occupancy
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [PTR_W:0]        r_count;
   logic                  w_pop;

   assign w_pop       = i_pop && !o_empty;
   assign o_empty     = (r_count == '0);
   assign o_full      = (r_count == (PTR_W+1)'(DEPTH));
   assign o_occupancy = r_count;

   // NOTE: storage is not reset; the head is masked to 0 while empty, so stale entries are never visible.
   always_ff @(posedge clk_i) begin
      if (i_push) r_mem[r_wr_ptr] <= i_data;
   end

   assign o_data = o_empty ? '0 : r_mem[r_rd_ptr];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_clear) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({i_push, w_pop})
            2'b10:   r_count <= r_count + (PTR_W+1)'(1);
            2'b01:   r_count <= r_count - (PTR_W+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni) !(i_push && o_full));

endmodule

// File: rtl/mac_stream_source.sv
// Streams trans_size words from TCDM starting at base_addr into a ready/valid output.
// Define MAC_STREAM_SOURCE_STATS_EN to build the grant-stall counter on stall_cnt_o.
module mac_stream_source
   import mac_package::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int LEN_WIDTH  = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  clear_i,
   input  logic                  req_start_i,
   input  logic [ADDR_WIDTH-1:0] base_addr_i,
   input  logic [LEN_WIDTH-1:0]  trans_size_i,
   output logic                  ready_start_o,
   output logic                  done_o,
   output logic                  tcdm_req_o,
   output logic [ADDR_WIDTH-1:0] tcdm_add_o,
   input  logic                  tcdm_gnt_i,
   input  logic                  tcdm_r_valid_i,
   input  logic [DATA_WIDTH-1:0] tcdm_r_data_i,
   output logic                  stream_valid_o,
   output logic [DATA_WIDTH-1:0] stream_data_o,
   input  logic                  stream_ready_i,
   output logic [31:0]           stall_cnt_o
);

   localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;

   mac_src_state_t        r_state;
   mac_src_state_t        w_state_next;
   mac_src_ctrl_t         w_ctrl;
   logic [ADDR_WIDTH-1:0] r_base;
   logic [LEN_WIDTH-1:0]  r_trans_size;
   logic [LEN_WIDTH-1:0]  r_issued_cnt;
   logic [LEN_WIDTH-1:0]  r_pop_cnt;
   logic [LEN_WIDTH-1:0]  w_last_idx;
   logic                  r_inflight;
   logic                  r_done_zero;
   logic                  w_req, w_grant, w_push, w_pop;
   logic                  w_full, w_empty, w_credit, w_done_last;
   logic [OCC_W-1:0]      w_occupancy;
   logic [OCC_W-1:0]      w_outstanding;

   assign w_ctrl = '{base_addr:  MAC_ADDR_W'(base_addr_i),
                     trans_size: MAC_LEN_W'(trans_size_i),
                     req_start:  req_start_i && (r_state == ST_IDLE) && !clear_i};

   // Responses return one cycle after grant, so at most one word is ever in flight.
   assign w_outstanding = w_occupancy + OCC_W'(r_inflight);
   assign w_credit      = (w_outstanding < OCC_W'(FIFO_DEPTH)) && !w_full;
   assign w_req         = (r_state == ST_ISSUE) && w_credit;
   assign w_grant       = w_req && tcdm_gnt_i;
   assign w_push        = tcdm_r_valid_i && r_inflight && !clear_i;
   assign w_pop         = stream_valid_o && stream_ready_i;
   assign w_last_idx    = r_trans_size - LEN_WIDTH'(1);

   assign ready_start_o  = (r_state == ST_IDLE);
   assign tcdm_req_o     = w_req;
   assign tcdm_add_o     = r_base + (ADDR_WIDTH'(r_issued_cnt) << 2);
   assign stream_valid_o = !w_empty;
   assign done_o         = (r_done_zero || w_done_last) && !clear_i;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_state <= ST_IDLE;
      else         r_state <= w_state_next;
   end

   // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
   always_comb begin
      w_state_next = r_state;
      w_done_last  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_ctrl.req_start && (w_ctrl.trans_size != '0)) w_state_next = ST_ISSUE;
         end
         ST_ISSUE: begin
            if (w_grant && (r_issued_cnt == w_last_idx)) w_state_next = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (w_pop && (r_pop_cnt == w_last_idx)) begin
               w_state_next = ST_IDLE;
               w_done_last  = 1'b1;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
      if (clear_i) begin
         w_state_next = ST_IDLE;
         w_done_last  = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_base       <= '0;
         r_trans_size <= '0;
         r_issued_cnt <= '0;
         r_pop_cnt    <= '0;
         r_inflight   <= 1'b0;
         r_done_zero  <= 1'b0;
      end else if (clear_i) begin
         r_issued_cnt <= '0;
         r_pop_cnt    <= '0;
         r_inflight   <= 1'b0;
         r_done_zero  <= 1'b0;
      end else begin
         r_inflight  <= w_grant;
         r_done_zero <= w_ctrl.req_start && (w_ctrl.trans_size == '0);
         if (w_ctrl.req_start) begin
            r_base       <= ADDR_WIDTH'(w_ctrl.base_addr);
            r_trans_size <= LEN_WIDTH'(w_ctrl.trans_size);
            r_issued_cnt <= '0;
            r_pop_cnt    <= '0;
         end else begin
            if (w_grant) r_issued_cnt <= r_issued_cnt + LEN_WIDTH'(1);
            if (w_pop)   r_pop_cnt    <= r_pop_cnt + LEN_WIDTH'(1);
         end
      end
   end

`ifdef MAC_STREAM_SOURCE_STATS_EN
   logic [31:0] r_stall_cnt;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                           r_stall_cnt <= '0;
      else if (clear_i || w_ctrl.req_start) r_stall_cnt <= '0;
      else if (w_req && !tcdm_gnt_i && (r_stall_cnt != '1))
         r_stall_cnt <= r_stall_cnt + 32'd1;
   end

   assign stall_cnt_o = r_stall_cnt;
`else
   assign stall_cnt_o = '0;
`endif

   mac_stream_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (FIFO_DEPTH)
   ) u_fifo (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .i_clear     (clear_i),
      .i_push      (w_push),
      .i_data      (tcdm_r_data_i),
      .i_pop       (w_pop),
      .o_data      (stream_data_o),
      .o_full      (w_full),
      .o_empty     (w_empty),
      .o_occupancy (w_occupancy)
   );

endmodule

// File: tb/tb_mac_stream_source.sv
// Directed bench for mac_stream_source with a one-cycle-latency TCDM responder.
module tb_mac_stream_source;

   logic        clk_i = 1'b0;
   logic        rst_ni, clear_i, req_start_i;
   logic [31:0] base_addr_i;
   logic [15:0] trans_size_i;
   logic        ready_start_o, done_o, tcdm_req_o;
   logic [31:0] tcdm_add_o;
   logic        tcdm_gnt_i, tcdm_r_valid_i;
   logic [31:0] tcdm_r_data_i;
   logic        stream_valid_o;
   logic [31:0] stream_data_o;
   logic        stream_ready_i;
   logic [31:0] stall_cnt_o;

`ifdef MAC_STREAM_SOURCE_STATS_EN
   localparam int EXP_STALL = 5;
`else
   localparam int EXP_STALL = 0;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   int cyc_no = 0;
   int n_grants, n_pops, n_done, done_cyc, last_pop_cyc, first_grant_cyc, first_valid_cyc;
   logic [31:0] g_addr [32];
   logic [31:0] p_data [32];

   always #5 clk_i = ~clk_i;

   mac_stream_source #(
      .DATA_WIDTH (32), .ADDR_WIDTH (32), .LEN_WIDTH (16), .FIFO_DEPTH (4)
   ) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .clear_i        (clear_i),
      .req_start_i    (req_start_i),
      .base_addr_i    (base_addr_i),
      .trans_size_i   (trans_size_i),
      .ready_start_o  (ready_start_o),
      .done_o         (done_o),
      .tcdm_req_o     (tcdm_req_o),
      .tcdm_add_o     (tcdm_add_o),
      .tcdm_gnt_i     (tcdm_gnt_i),
      .tcdm_r_valid_i (tcdm_r_valid_i),
      .tcdm_r_data_i  (tcdm_r_data_i),
      .stream_valid_o (stream_valid_o),
      .stream_data_o  (stream_data_o),
      .stream_ready_i (stream_ready_i),
      .stall_cnt_o    (stall_cnt_o)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]};
   endfunction

   task automatic clr_log();
      n_grants = 0; n_pops = 0; n_done = 0;
      done_cyc = -1; last_pop_cyc = -2; first_grant_cyc = -1; first_valid_cyc = -1;
   endtask

   // One clock: log handshakes just before the edge, then play the memory response.
   task automatic cyc();
      logic        g;
      logic [31:0] a;
      #1;
      g = tcdm_req_o & tcdm_gnt_i;
      a = tcdm_add_o;
      if (g) begin
         if (n_grants == 0) first_grant_cyc = cyc_no;
         if (n_grants < 32) g_addr[n_grants] = a;
         n_grants++;
      end
      if (stream_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc_no;
      if (stream_valid_o && stream_ready_i) begin
         if (n_pops < 32) p_data[n_pops] = stream_data_o;
         n_pops++;
         last_pop_cyc = cyc_no;
      end
      if (done_o) begin
         n_done++;
         done_cyc = cyc_no;
      end
      @(posedge clk_i); #1;
      cyc_no++;
      tcdm_r_valid_i = g;
      tcdm_r_data_i  = g ? mem_word(a) : 32'h0;
   endtask

   task automatic start(input logic [31:0] base, input logic [15:0] size);
      base_addr_i  = base;
      trans_size_i = size;
      req_start_i  = 1'b1;
      cyc();
      req_start_i  = 1'b0;
   endtask

   task automatic run_until_done(input string name, input int budget);
      int k = 0;
      while (n_done == 0 && k < budget) begin
         cyc();
         k++;
      end
      n_tests++;
      if (n_done == 0) begin
         n_fail++;
         $display("FAIL %s_timeout: no done_o within %0d cycles", name, budget);
      end
   endtask

   task automatic test_reset();
      n_tests++;
      if ({ready_start_o, done_o, tcdm_req_o, stream_valid_o} !== 4'b1000) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b expected 1000", {ready_start_o, done_o, tcdm_req_o, stream_valid_o});
      end
      n_tests++;
      if (tcdm_add_o !== 32'h0) begin
         n_fail++; $display("FAIL reset_addr: got %h expected 00000000", tcdm_add_o);
      end
      n_tests++;
      if (stream_data_o !== 32'h0) begin
         n_fail++; $display("FAIL reset_data: got %h expected 00000000", stream_data_o);
      end
      n_tests++;
      if (stall_cnt_o !== 32'h0) begin
         n_fail++; $display("FAIL reset_stall: got %0d expected 0", stall_cnt_o);
      end
   endtask

   task automatic test_basic();
      clr_log();
      tcdm_gnt_i = 1'b1; stream_ready_i = 1'b1;
      start(32'h1000, 16'd4);
      run_until_done("basic", 40);
      n_tests++;
      if (n_grants != 4 || n_pops != 4 || n_done != 1) begin
         n_fail++;
         $display("FAIL basic_counts: got grants=%0d pops=%0d done=%0d expected 4/4/1", n_grants, n_pops, n_done);
      end
      for (int i = 0; i < 4; i++) begin
         n_tests++;
         if (g_addr[i] !== 32'h1000 + 32'(4 * i) || p_data[i] !== mem_word(32'h1000 + 32'(4 * i))) begin
            n_fail++;
            $display("FAIL basic_word%0d: got addr=%h data=%h expected addr=%h data=%h", i, g_addr[i], p_data[i],
                     32'h1000 + 32'(4 * i), mem_word(32'h1000 + 32'(4 * i)));
         end
      end
      n_tests++;
      if (done_cyc != last_pop_cyc) begin
         n_fail++; $display("FAIL basic_done_timing: got cycle %0d expected %0d", done_cyc, last_pop_cyc);
      end
      n_tests++;
      if (first_valid_cyc - first_grant_cyc != 2) begin
         n_fail++; $display("FAIL basic_latency: got %0d expected 2", first_valid_cyc - first_grant_cyc);
      end
      #1;
      n_tests++;
      if (ready_start_o !== 1'b1 || done_o !== 1'b0) begin
         n_fail++; $display("FAIL basic_idle: got ready=%b done=%b expected 1/0", ready_start_o, done_o);
      end
   endtask

   task automatic test_backpressure();
      clr_log();
      tcdm_gnt_i = 1'b1; stream_ready_i = 1'b0;
      start(32'h2000, 16'd8);
      repeat (20) cyc();
      #1;
      n_tests++;
      if (n_grants != 4 || tcdm_req_o !== 1'b0) begin
         n_fail++; $display("FAIL bp_credit: got grants=%0d req=%b expected 4/0", n_grants, tcdm_req_o);
      end
      n_tests++;
      if (stream_valid_o !== 1'b1 || stream_data_o !== mem_word(32'h2000)) begin
         n_fail++;
         $display("FAIL bp_head: got valid=%b data=%h expected 1/%h", stream_valid_o, stream_data_o, mem_word(32'h2000));
      end
      stream_ready_i = 1'b1;
      run_until_done("bp", 60);
      n_tests++;
      if (n_grants != 8 || n_pops != 8 || n_done != 1) begin
         n_fail++;
         $display("FAIL bp_counts: got grants=%0d pops=%0d done=%0d expected 8/8/1", n_grants, n_pops, n_done);
      end
      for (int i = 0; i < 8; i++) begin
         n_tests++;
         if (p_data[i] !== mem_word(32'h2000 + 32'(4 * i))) begin
            n_fail++;
            $display("FAIL bp_data%0d: got %h expected %h", i, p_data[i], mem_word(32'h2000 + 32'(4 * i)));
         end
      end
   endtask

   task automatic test_grant_stall();
      int bad = 0;
      clr_log();
      stream_ready_i = 1'b1;
      tcdm_gnt_i = 1'b0;
      start(32'h3000, 16'd2);
      repeat (5) begin
         #1;
         if (tcdm_req_o !== 1'b1 || tcdm_add_o !== 32'h3000) bad++;
         cyc();
      end
      n_tests++;
      if (bad != 0) begin
         n_fail++; $display("FAIL stall_hold: got %0d bad cycles expected 0", bad);
      end
      tcdm_gnt_i = 1'b1;
      run_until_done("stall", 30);
      n_tests++;
      if (n_grants != 2 || g_addr[0] !== 32'h3000 || g_addr[1] !== 32'h3004) begin
         n_fail++;
         $display("FAIL stall_addr: got n=%0d %h %h expected 2 00003000 00003004", n_grants, g_addr[0], g_addr[1]);
      end
      n_tests++;
      if (stall_cnt_o !== 32'(EXP_STALL)) begin
         n_fail++; $display("FAIL stall_cnt: got %0d expected %0d", stall_cnt_o, EXP_STALL);
      end
   endtask

   task automatic test_zero_and_busy();
      clr_log();
      tcdm_gnt_i = 1'b1; stream_ready_i = 1'b1;
      start(32'h7000, 16'd0);
      #1;
      n_tests++;
      if (done_o !== 1'b1 || tcdm_req_o !== 1'b0 || ready_start_o !== 1'b1) begin
         n_fail++;
         $display("FAIL zero_done: got done=%b req=%b ready=%b expected 1/0/1", done_o, tcdm_req_o, ready_start_o);
      end
      cyc();
      #1;
      n_tests++;
      if (done_o !== 1'b0 || n_grants != 0) begin
         n_fail++; $display("FAIL zero_after: got done=%b grants=%0d expected 0/0", done_o, n_grants);
      end
      clr_log();
      start(32'h4000, 16'd3);
      base_addr_i = 32'h9000; trans_size_i = 16'd7; req_start_i = 1'b1;
      #1;
      n_tests++;
      if (ready_start_o !== 1'b0) begin
         n_fail++; $display("FAIL busy_ready: got %b expected 0", ready_start_o);
      end
      cyc(); cyc();
      req_start_i = 1'b0;
      run_until_done("busy", 30);
      n_tests++;
      if (n_grants != 3 || n_done != 1) begin
         n_fail++; $display("FAIL busy_counts: got grants=%0d done=%0d expected 3/1", n_grants, n_done);
      end
      for (int i = 0; i < 3; i++) begin
         n_tests++;
         if (g_addr[i] !== 32'h4000 + 32'(4 * i)) begin
            n_fail++; $display("FAIL busy_addr%0d: got %h expected %h", i, g_addr[i], 32'h4000 + 32'(4 * i));
         end
      end
   endtask

   task automatic test_wrap();
      clr_log();
      tcdm_gnt_i = 1'b1; stream_ready_i = 1'b1;
      start(32'hFFFF_FFFC, 16'd2);
      run_until_done("wrap", 30);
      n_tests++;
      if (n_grants != 2 || g_addr[0] !== 32'hFFFF_FFFC || g_addr[1] !== 32'h0000_0000) begin
         n_fail++;
         $display("FAIL wrap_addr: got n=%0d %h %h expected 2 fffffffc 00000000", n_grants, g_addr[0], g_addr[1]);
      end
      n_tests++;
      if (p_data[1] !== mem_word(32'h0)) begin
         n_fail++; $display("FAIL wrap_data: got %h expected %h", p_data[1], mem_word(32'h0));
      end
   endtask

   task automatic test_clear();
      clr_log();
      tcdm_gnt_i = 1'b1; stream_ready_i = 1'b0;
      start(32'h5000, 16'd6);
      cyc(); cyc();
      n_tests++;
      if (n_grants != 2) begin
         n_fail++; $display("FAIL clear_pre: got grants=%0d expected 2", n_grants);
      end
      clear_i = 1'b1;
      cyc();
      clear_i = 1'b0;
      #1;
      n_tests++;
      if ({ready_start_o, stream_valid_o, tcdm_req_o, done_o} !== 4'b1000 || stall_cnt_o !== 32'h0) begin
         n_fail++;
         $display("FAIL clear_state: got %b stall=%0d expected 1000 stall=0",
                  {ready_start_o, stream_valid_o, tcdm_req_o, done_o}, stall_cnt_o);
      end
      repeat (3) cyc();
      n_tests++;
      if (stream_valid_o !== 1'b0 || n_done != 0) begin
         n_fail++; $display("FAIL clear_drop: got valid=%b done=%0d expected 0/0", stream_valid_o, n_done);
      end
      clr_log();
      stream_ready_i = 1'b1;
      start(32'h6000, 16'd1);
      run_until_done("clear_next", 20);
      n_tests++;
      if (n_grants != 1 || g_addr[0] !== 32'h6000 || n_pops != 1 || p_data[0] !== mem_word(32'h6000)) begin
         n_fail++;
         $display("FAIL clear_next: got grants=%0d addr=%h pops=%0d data=%h expected 1/00006000/1/%h",
                  n_grants, g_addr[0], n_pops, p_data[0], mem_word(32'h6000));
      end
   endtask

   task automatic test_reset_mid();
      clr_log();
      tcdm_gnt_i = 1'b1; stream_ready_i = 1'b0;
      start(32'h8000, 16'd4);
      cyc(); cyc();
      rst_ni = 1'b0;
      #1;
      n_tests++;
      if ({ready_start_o, stream_valid_o, tcdm_req_o, done_o} !== 4'b1000 || tcdm_add_o !== 32'h0) begin
         n_fail++;
         $display("FAIL rst_mid_state: got %b addr=%h expected 1000 addr=00000000",
                  {ready_start_o, stream_valid_o, tcdm_req_o, done_o}, tcdm_add_o);
      end
      cyc(); cyc();
      rst_ni = 1'b1;
      stream_ready_i = 1'b1;
      repeat (4) cyc();
      n_tests++;
      if (n_done != 0 || stream_valid_o !== 1'b0) begin
         n_fail++; $display("FAIL rst_mid_done: got done=%0d valid=%b expected 0/0", n_done, stream_valid_o);
      end
   endtask

   initial begin
      rst_ni = 1'b0; clear_i = 1'b0; req_start_i = 1'b0;
      base_addr_i = '0; trans_size_i = '0;
      tcdm_gnt_i = 1'b0; tcdm_r_valid_i = 1'b0; tcdm_r_data_i = '0;
      stream_ready_i = 1'b0;
      clr_log();
      repeat (2) @(posedge clk_i);
      #1;
      test_reset();
      rst_ni = 1'b1;
      cyc(); cyc();
      test_basic();
      test_backpressure();
      test_grant_stall();
      test_zero_and_busy();
      test_wrap();
      test_clear();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
